// File: rtl/kanagawa_rob_pkg.sv
// kanagawa_rob_pkg: shared width helpers and slot-ID field extraction for the reorder buffer.
`default_nettype none

package kanagawa_rob_pkg;

    localparam int MAX_WORD_W = 1024;
    localparam int MAX_SID_W  = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? clog2(depth) : 1;
    endfunction

    function automatic int ptr_width(input int slot_id_width);
        return slot_id_width;
    endfunction

    // Callers zero-extend the data word to MAX_WORD_W and truncate the result to their field width.
    function automatic logic [MAX_SID_W-1:0] slot_field(
        input logic [MAX_WORD_W-1:0] word,
        input int                    offset,
        input int                    width
    );
        logic [MAX_WORD_W-1:0] shifted;
        logic [MAX_SID_W-1:0]  mask;
        shifted = word >> offset;
        mask    = (MAX_SID_W'(1) << width) - MAX_SID_W'(1);
        return MAX_SID_W'(shifted) & mask;
    endfunction

endpackage : kanagawa_rob_pkg

`default_nettype wire

// File: rtl/kanagawa_rob_slot_array.sv
// kanagawa_rob_slot_array: per-slot valid/generation bits and data storage,
// one write port, one combinational read port, clear-on-read.
`default_nettype none

module kanagawa_rob_slot_array
    import kanagawa_rob_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_tag_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_hit_o,
    input  logic             clr_en_i,
    input  logic [IDX_W-1:0] clr_idx_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic             rd_tag_o,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] tag_q;
    logic [DEPTH-1:0] tag_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // A write lands after the clear so that a next-generation write to the popping slot survives.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (clr_en_i) begin
            valid_d[clr_idx_i] = 1'b0;
        end
        if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
            tag_d[wr_idx_i]   = wr_tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign wr_hit_o   = valid_q[wr_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = mem_q[rd_idx_i];

endmodule : kanagawa_rob_slot_array

`default_nettype wire

// File: rtl/kanagawa_reorder_buffer.sv
// kanagawa_reorder_buffer: accepts slot-tagged words in any order, releases them in ascending slot-ID order.
// Define REORDER_BUFFER_ASSERT_EN to compile simulation-only protocol assertions.
`default_nettype none

module kanagawa_reorder_buffer
    import kanagawa_rob_pkg::*;
#(
    parameter int    WIDTH              = 32,
    parameter int    DEPTH              = 32,
    parameter int    SLOT_ID_OFFSET     = 0,
    parameter int    SLOT_ID_WIDTH      = 6,
    parameter int    ALMOST_FULL_SLACK  = 2,
    parameter int    ALMOST_EMPTY_LEVEL = 1,
    parameter string DEVICE_FAMILY      = "Stratix10",
    localparam int   IDX_W              = idx_width(DEPTH),
    localparam int   PTR_W              = ptr_width(SLOT_ID_WIDTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    output logic             full,
    output logic             almost_full,
    output logic [IDX_W:0]   usedw,
    output logic             overflow_out,
    input  logic             rdreq,
    output logic             empty,
    output logic             almost_empty,
    output logic [WIDTH-1:0] q,
    output logic             underflow_out
);

    localparam int CNT_W = IDX_W + 1;
    localparam int AF_THRESH = (DEPTH > ALMOST_FULL_SLACK) ? (DEPTH - ALMOST_FULL_SLACK) : 0;
    localparam logic [CNT_W-1:0] C_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF_THRESH = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] C_AE_LEVEL  = CNT_W'(ALMOST_EMPTY_LEVEL);

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] usedw_q;
    logic [CNT_W-1:0] usedw_d;
    logic             overflow_q;
    logic             underflow_q;

    logic [PTR_W-1:0] wr_sid;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_gen;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_gen;
    logic             head_valid;
    logic             head_tag;
    logic [WIDTH-1:0] head_data;
    logic             wr_slot_busy;
    logic             wr_accept;
    logic             rd_accept;
    logic             wr_adds_entry;

    assign wr_sid = PTR_W'(slot_field(MAX_WORD_W'(data), SLOT_ID_OFFSET, SLOT_ID_WIDTH));
    assign wr_idx = wr_sid[IDX_W-1:0];
    assign wr_gen = wr_sid[PTR_W-1];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];
    assign rd_gen = rd_ptr_q[PTR_W-1];

    kanagawa_rob_slot_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_slot_array (
        .clk_i      (clock),
        .rst_ni     (rst),
        .wr_en_i    (wr_accept),
        .wr_idx_i   (wr_idx),
        .wr_tag_i   (wr_gen),
        .wr_data_i  (data),
        .wr_hit_o   (wr_slot_busy),
        .clr_en_i   (rd_accept),
        .clr_idx_i  (rd_idx),
        .rd_idx_i   (rd_idx),
        .rd_valid_o (head_valid),
        .rd_tag_o   (head_tag),
        .rd_data_o  (head_data)
    );

    // Entries from the other generation sit in the head slot without making it readable.
    assign empty        = !(head_valid && (head_tag == rd_gen));
    assign full         = (usedw_q == C_DEPTH_CNT);
    assign almost_full  = (usedw_q >= C_AF_THRESH);
    assign almost_empty = (usedw_q <= C_AE_LEVEL);
    assign usedw        = usedw_q;
    assign q            = head_data;
    assign overflow_out  = overflow_q;
    assign underflow_out = underflow_q;

    assign wr_accept = wrreq && !full;
    assign rd_accept = rdreq && !empty;

    // Overwriting a live slot keeps the count, unless that slot is the head being popped this cycle.
    assign wr_adds_entry = wr_accept && (!wr_slot_busy || (rd_accept && (wr_idx == rd_idx)));

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q + CNT_W'(wr_adds_entry) - CNT_W'(rd_accept);
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rd_ptr_q    <= '0;
            usedw_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            usedw_q     <= usedw_d;
            overflow_q  <= wrreq && full;
            underflow_q <= rdreq && empty;
        end
    end

`ifdef REORDER_BUFFER_ASSERT_EN
    initial begin
        if (SLOT_ID_WIDTH != IDX_W + 1) begin
            $error("kanagawa_reorder_buffer: SLOT_ID_WIDTH=%0d must be log2(DEPTH)+1=%0d",
                   SLOT_ID_WIDTH, IDX_W + 1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            if (wrreq && full) begin
                $error("kanagawa_reorder_buffer: write while full");
            end
            if (rdreq && empty) begin
                $error("kanagawa_reorder_buffer: read while empty");
            end
            if (wr_accept && wr_slot_busy && !(rd_accept && (wr_idx == rd_idx))) begin
                $error("kanagawa_reorder_buffer: write to occupied slot %0d", wr_idx);
            end
        end
    end
`endif

endmodule : kanagawa_reorder_buffer

`default_nettype wire

// File: tb/tb_kanagawa_reorder_buffer.sv
// tb_kanagawa_reorder_buffer: scoreboard bench for the reorder buffer (DEPTH=32, 6-bit slot ID at bit 0).
`default_nettype none

module tb_kanagawa_reorder_buffer;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 32;
    localparam int ROUNDS   = 1000;
    localparam int WAIT_MAX = 2000;

    logic             clock;
    logic             rst;
    logic             wrreq;
    logic [WIDTH-1:0] data;
    logic             full;
    logic             almost_full;
    logic [5:0]       usedw;
    logic             overflow_out;
    logic             rdreq;
    logic             empty;
    logic             almost_empty;
    logic [WIDTH-1:0] q;
    logic             underflow_out;

    int               n_checks;
    int               n_fail;
    logic [WIDTH-1:0] sb[$];
    bit               busy[DEPTH];

    kanagawa_reorder_buffer #(
        .WIDTH              (WIDTH),
        .DEPTH              (DEPTH),
        .SLOT_ID_OFFSET     (0),
        .SLOT_ID_WIDTH      (6),
        .ALMOST_FULL_SLACK  (2),
        .ALMOST_EMPTY_LEVEL (1),
        .DEVICE_FAMILY      ("Stratix10")
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .wrreq         (wrreq),
        .data          (data),
        .full          (full),
        .almost_full   (almost_full),
        .usedw         (usedw),
        .overflow_out  (overflow_out),
        .rdreq         (rdreq),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .q             (q),
        .underflow_out (underflow_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mk_word(input int idx, input int gen, input int other);
        logic [WIDTH-1:0] w;
        w        = '0;
        w[4:0]   = idx[4:0];
        w[5]     = gen[0];
        w[31:6]  = other[25:0];
        return w;
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [WIDTH-1:0] w);
        wrreq = 1'b1;
        data  = w;
        next_cycle();
        wrreq = 1'b0;
    endtask

    task automatic pop_and_check(input string tag);
        logic [WIDTH-1:0] exp;
        exp = sb.pop_front();
        check(tag, q, exp);
        rdreq = 1'b1;
        next_cycle();
        rdreq = 1'b0;
    endtask

    task automatic rand_stall();
        if ($urandom_range(15, 0) == 0) begin
            int k;
            k = $urandom_range(10, 1);
            repeat (k) next_cycle();
        end
    endtask

    task automatic run_random_rounds();
        fork
            begin
                for (int r = 0; r < ROUNDS; r++) begin
                    int order[DEPTH];
                    for (int i = 0; i < DEPTH; i++) order[i] = i;
                    for (int i = DEPTH - 1; i > 0; i--) begin
                        int j;
                        int t;
                        j = $urandom_range(i, 0);
                        t = order[i];
                        order[i] = order[j];
                        order[j] = t;
                    end
                    for (int s = 0; s < DEPTH; s++) sb.push_back(mk_word(s, r % 2, s + (r % 15)));
                    for (int i = 0; i < DEPTH; i++) begin
                        int idx;
                        int w;
                        idx = order[i];
                        w   = 0;
                        rand_stall();
                        while ((full || busy[idx]) && w < WAIT_MAX) begin
                            next_cycle();
                            w++;
                        end
                        if (w >= WAIT_MAX) check("rnd_wr_wait", {full, busy[idx]}, 0);
                        busy[idx] = 1'b1;
                        write_word(mk_word(idx, r % 2, idx + (r % 15)));
                    end
                end
            end
            begin
                for (int n = 0; n < ROUNDS * DEPTH; n++) begin
                    int w;
                    w = 0;
                    rand_stall();
                    while (empty && w < WAIT_MAX) begin
                        next_cycle();
                        w++;
                    end
                    busy[n % DEPTH] = 1'b0;
                    if (w >= WAIT_MAX) begin
                        check("rnd_rd_wait", empty, 0);
                        if (sb.size() > 0) void'(sb.pop_front());
                    end else begin
                        pop_and_check("rnd_q");
                    end
                end
            end
        join
    endtask

    initial begin
        #950000;
        n_fail++;
        $display("FAIL watchdog: actual=time limit reached expected=test complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        wrreq    = 1'b0;
        rdreq    = 1'b0;
        data     = '0;
        repeat (50) @(posedge clock);
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_usedw", usedw, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_overflow", overflow_out, 0);
        check("rst_underflow", underflow_out, 0);
        rst = 1'b1;
        next_cycle();
        check("post_rst_empty", empty, 1);
        check("post_rst_underflow", underflow_out, 0);

        // Read on an empty buffer.
        rdreq = 1'b1;
        next_cycle();
        rdreq = 1'b0;
        check("underflow_pulse", underflow_out, 1);
        check("underflow_usedw", usedw, 0);
        check("underflow_empty", empty, 1);
        next_cycle();
        check("underflow_clear", underflow_out, 0);

        // Reverse-order fill, generation 0.
        for (int s = 0; s < DEPTH; s++) sb.push_back(mk_word(s, 0, s + 3));
        for (int i = 0; i < DEPTH; i++) begin
            int s;
            s = DEPTH - 1 - i;
            write_word(mk_word(s, 0, s + 3));
            check("fill_empty", empty, (s != 0));
            check("fill_usedw", usedw, i + 1);
            check("fill_almost_full", almost_full, (i + 1 >= DEPTH - 2));
        end
        check("fill_full", full, 1);

        // Dropped write while full; slot 5 must keep its original content.
        write_word(mk_word(5, 0, 12'h777));
        check("overflow_pulse", overflow_out, 1);
        check("overflow_usedw", usedw, DEPTH);
        check("overflow_full", full, 1);
        next_cycle();
        check("overflow_clear", overflow_out, 0);

        for (int i = 0; i < DEPTH; i++) pop_and_check("fill_q");
        check("drain_empty", empty, 1);
        check("drain_usedw", usedw, 0);
        check("drain_almost_empty", almost_empty, 1);

        // Write then read in back-to-back cycles, one full lap at generation 1.
        for (int k = 0; k < DEPTH; k++) begin
            check("b2b_pre_empty", empty, 1);
            sb.push_back(mk_word(k, 1, k + 100));
            write_word(mk_word(k, 1, k + 100));
            check("b2b_empty_after_wr", empty, 0);
            pop_and_check("b2b_q");
            check("b2b_empty_after_rd", empty, 1);
        end

        run_random_rounds();
        check("rnd_sb_drained", sb.size(), 0);
        check("rnd_end_usedw", usedw, 0);

        // Head pointer is back at generation 0, slot 0: a generation-1 entry there must be held.
        write_word(mk_word(0, 1, 8'h55));
        for (int i = 0; i < 3; i++) begin
            check("gen_mismatch_empty", empty, 1);
            next_cycle();
        end
        check("gen_mismatch_usedw", usedw, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_kanagawa_reorder_buffer

`default_nettype wire

// File: doc/kanagawa_reorder_buffer.md
Name: kanagawa_reorder_buffer

Overview:
- FIFO-style reorder buffer: entries arrive in any order, each carrying a slot ID inside the data word; they leave in strictly ascending slot-ID order.
- Sits between out-of-order producers (e.g. parallel pipelines) and an in-order consumer.
- Exposes a standard show-ahead FIFO interface (wrreq/full, rdreq/empty/q).

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of slots; power of two, at least 2.
- SLOT_ID_OFFSET, 0, bit position of the slot-ID field LSB inside data.
- SLOT_ID_WIDTH, 6, slot-ID field width; must equal log2(DEPTH)+1. Low log2(DEPTH) bits are the slot index; MSB is the generation bit.
- ALMOST_FULL_SLACK, 2, almost_full asserts when usedw >= DEPTH-ALMOST_FULL_SLACK.
- ALMOST_EMPTY_LEVEL, 1, almost_empty asserts when usedw <= ALMOST_EMPTY_LEVEL.
- DEVICE_FAMILY, "Stratix10", target family string; no functional effect.

Ports:
- clock, in, 1, sole clock; all state on rising edge.
- rst, in, 1, asynchronous, active-low reset (0 = reset).
- wrreq, in, 1, write strobe.
- data, in, WIDTH, write word including the slot-ID field.
- full, out, 1, no free slot.
- almost_full, out, 1, see ALMOST_FULL_SLACK.
- usedw, out, log2(DEPTH)+1, number of occupied slots.
- overflow_out, out, 1, pulse: write dropped.
- rdreq, in, 1, pop head entry.
- empty, out, 1, head slot not ready.
- almost_empty, out, 1, see ALMOST_EMPTY_LEVEL.
- q, out, WIDTH, head entry, bit-exact copy of the written word.
- underflow_out, out, 1, pulse: read while empty.

Behaviour:
- State:
  - rd_ptr: SLOT_ID_WIDTH bits. Index = low bits; generation = MSB.
  - Per-slot valid bit and generation tag.
  - Data array of DEPTH x WIDTH. Not reset.
  - Occupancy counter.
- Reset (rst=0, asynchronous):
  - rd_ptr=0, all valid=0, counter=0.
  - Outputs: full=0, empty=1, usedw=0, almost_full=0, almost_empty=1, overflow_out=0, underflow_out=0.
  - q is don't-care while empty.
- Write, accepted when wrreq=1 and full=0:
  - sid = data[SLOT_ID_OFFSET +: SLOT_ID_WIDTH]; idx = low bits of sid.
  - mem[idx] <= data; valid[idx] <= 1; tag[idx] <= MSB of sid.
- Empty:
  - empty = !(valid[rd_ptr.idx] && tag[rd_ptr.idx] == rd_ptr.msb), decoded from registered state.
  - A write to the head slot deasserts empty on the next cycle (1-cycle write-to-read latency).
- Read:
  - Show-ahead: q = mem[rd_ptr.idx] whenever empty=0.
  - rdreq=1 with empty=0 clears valid[idx] and increments rd_ptr modulo 2^SLOT_ID_WIDTH, toggling the generation bit each DEPTH reads.
- Occupancy:
  - usedw increments on an accepted write and decrements on an accepted read; both in the same cycle leaves it unchanged.
  - full = (usedw == DEPTH), evaluated on registered usedw.
  - A simultaneous read does not unblock a write in that same cycle.
- Same cycle write and read of the same index (next-generation write while the head pops): the write wins; valid stays 1 with the new tag.
- Errors:
  - wrreq while full: write dropped; overflow_out=1 for exactly the next cycle.
  - rdreq while empty: no state change; underflow_out=1 for the next cycle.
  - A write to an already-valid slot is a protocol violation. It is accepted and overwrites the slot, with usedw unchanged.
- Entries whose tag mismatches the head generation are held; they do not satisfy the empty check.
- Throughput: one write and one read per cycle.

Optional Feature:
- REORDER_BUFFER_ASSERT_EN defined: simulation-only assertions fire $error on:
  - wrreq while full;
  - rdreq while empty;
  - write to an already-valid slot;
  - SLOT_ID_WIDTH != log2(DEPTH)+1 (elaboration check).
- Undefined: no assertion code is compiled; the RTL is otherwise identical.

Decomposition:
- Package kanagawa_rob_pkg:
  - function clog2;
  - localparam-style helpers for index width (log2(DEPTH)) and ptr width (SLOT_ID_WIDTH);
  - slot-field extract function.
- One sub-module, kanagawa_rob_slot_array: valid/tag bits plus data memory, one write port, one combinational read port, and clear-on-read.

Test Plan:
- Reset held 50 cycles, then released: empty=1, full=0, usedw=0, no pulses.
- DEPTH=32, write slots 31 down to 0 (generation 0), other_data=slot+3:
  - empty stays 1 until slot 0 is written;
  - full=1 after the 32nd write;
  - reads return slot 0..31 in order with other_data 3..34.
- 1000 rounds of shuffled slot order with generation alternating 0/1 and other_data=slot+(round%15), random stalls of 1-10 cycles on both sides: every round yields 32 entries in slot order with correct other_data.
- Write slot 0 then read in back-to-back cycles: empty=0 exactly 1 cycle after the write; q bit-exact; empty=1 after the pop.
- Full buffer, wrreq held: overflow_out pulses 1 cycle; no state change; usedw=32.
- rdreq on empty: underflow_out pulses 1 cycle. Generation-1 slot 0 written while rd_ptr is still generation 0: empty stays 1.
